// File: rtl/icache_tag_array_if.sv
// Fetch/refill-side bus of the I-cache tag store: lookup, write, invalidate and response.
// Master is the fetch/refill side; slave is the tag array itself.
interface icache_tag_array_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 128,
  parameter int TAG_W = 18
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic                  lk_en;
  logic [IDX_W-1:0]      lk_index;
  logic [TAG_W-1:0]      lk_tag;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_index;
  logic [WAY_W-1:0]      wr_way;
  logic [TAG_W-1:0]      wr_tag;
  logic                  inv_all;
  logic                  busy;
  logic                  rsp_valid;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAYS*TAG_W-1:0] tags_out;
  logic [WAYS-1:0]       valid_out;
  logic                  parity_err;

  modport master (
    output lk_en, lk_index, lk_tag, wr_en, wr_index, wr_way, wr_tag, inv_all,
    input  busy, rsp_valid, hit, hit_way, tags_out, valid_out, parity_err
  );

  modport slave (
    input  lk_en, lk_index, lk_tag, wr_en, wr_index, wr_way, wr_tag, inv_all,
    output busy, rsp_valid, hit, hit_way, tags_out, valid_out, parity_err
  );
endinterface

// File: rtl/icache_tag_array.sv
// Set-associative I-cache tags, 2-cycle fully pipelined lookup with write forwarding; no backpressure,
// writes/invalidates ignored while busy sweeps. Optional tag parity via ICACHE_TAG_PARITY_EN.
module icache_tag_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 128,
  parameter int TAG_W = 18
) (
  input logic clk,
  input logic rst,
  icache_tag_array_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
`ifdef ICACHE_TAG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENT_W = TAG_W + PAR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  function automatic logic [ENT_W-1:0] mk_ent(input logic [TAG_W-1:0] t);
`ifdef ICACHE_TAG_PARITY_EN
    return {^t, t};
`else
    return t;
`endif
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep_clr;
  logic             busy;
  logic             wr_eff;

  assign busy     = (state_q == SWEEP);
  assign bus.busy = busy;
  assign wr_eff   = bus.wr_en && !busy && !rst;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sweep_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.inv_all) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d   = SWEEP;
      cnt_d     = '0;
      sweep_clr = 1'b0;
    end
  end

  // Arrays carry no reset; the post-reset sweep is what clears the valid bits.
  logic [WAYS-1:0][ENT_W-1:0] tag_ram [SETS];
  logic [WAYS-1:0]            vld_ram [SETS];
  logic [WAYS-1:0][ENT_W-1:0] tag_q;
  logic [WAYS-1:0]            vld_q;

  always_ff @(posedge clk) begin
    if (wr_eff) tag_ram[bus.wr_index][bus.wr_way] <= mk_ent(bus.wr_tag);
    tag_q <= tag_ram[bus.lk_index];
  end

  always_ff @(posedge clk) begin
    if (sweep_clr) vld_ram[cnt_q] <= '0;
    else if (wr_eff) vld_ram[bus.wr_index][bus.wr_way] <= 1'b1;
    vld_q <= vld_ram[bus.lk_index];
  end

  logic             s1_vld, s1_busy, s1_fwd;
  logic [IDX_W-1:0] s1_index;
  logic [TAG_W-1:0] s1_tag;
  logic [WAY_W-1:0] s1_fwd_way;
  logic [ENT_W-1:0] s1_fwd_ent;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_busy <= 1'b0;
      s1_fwd  <= 1'b0;
    end else begin
      s1_vld  <= bus.lk_en;
      s1_busy <= busy;
      s1_fwd  <= wr_eff && (bus.wr_index == bus.lk_index);
    end
  end

  always_ff @(posedge clk) begin
    s1_index   <= bus.lk_index;
    s1_tag     <= bus.lk_tag;
    s1_fwd_way <= bus.wr_way;
    s1_fwd_ent <= mk_ent(bus.wr_tag);
  end

  // Same-edge write missed the RAM read; next-edge write arrives in time for the compare.
  logic [WAYS-1:0][ENT_W-1:0] eff_ent;
  logic [WAYS-1:0]            eff_vld;
  logic [WAYS-1:0]            match;
  logic [WAY_W-1:0]           hit_w;
  logic [WAYS*TAG_W-1:0]      tags_d;
`ifdef ICACHE_TAG_PARITY_EN
  logic [WAYS-1:0]            par_bad;
`endif

  always_comb begin
    eff_ent = tag_q;
    eff_vld = vld_q;
    if (s1_fwd) begin
      eff_ent[s1_fwd_way] = s1_fwd_ent;
      eff_vld[s1_fwd_way] = 1'b1;
    end
    if (wr_eff && (bus.wr_index == s1_index)) begin
      eff_ent[bus.wr_way] = mk_ent(bus.wr_tag);
      eff_vld[bus.wr_way] = 1'b1;
    end
    if (s1_busy) eff_vld = '0;

    match  = '0;
    tags_d = '0;
    hit_w  = '0;
`ifdef ICACHE_TAG_PARITY_EN
    par_bad = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
      tags_d[w*TAG_W +: TAG_W] = eff_ent[w][TAG_W-1:0];
`ifdef ICACHE_TAG_PARITY_EN
      par_bad[w] = eff_vld[w] & (^eff_ent[w]);
      match[w]   = eff_vld[w] & ~(^eff_ent[w]) & (eff_ent[w][TAG_W-1:0] == s1_tag);
`else
      match[w]   = eff_vld[w] & (eff_ent[w][TAG_W-1:0] == s1_tag);
`endif
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_w = WAY_W'(w);
    end
  end

  logic                  rsp_q, hit_q;
  logic [WAY_W-1:0]      hit_way_q;
  logic [WAYS*TAG_W-1:0] tags_q;
  logic [WAYS-1:0]       valid_q;

  always_ff @(posedge clk) begin
    if (rst || !s1_vld) begin
      rsp_q     <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      tags_q    <= '0;
      valid_q   <= '0;
    end else begin
      rsp_q     <= 1'b1;
      hit_q     <= |match;
      hit_way_q <= hit_w;
      tags_q    <= tags_d;
      valid_q   <= eff_vld;
    end
  end

`ifdef ICACHE_TAG_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= s1_vld && (|par_bad);
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rsp_valid = rsp_q;
  assign bus.hit       = hit_q;
  assign bus.hit_way   = hit_way_q;
  assign bus.tags_out  = tags_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_icache_tag_array.sv
// Directed, table-driven bench for icache_tag_array (default 4-way/128-set/18-bit build).
// The parity sequence is compiled only when ICACHE_TAG_PARITY_EN is defined.
module tb_icache_tag_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_tag_array_if #(.WAYS(4), .SETS(128), .TAG_W(18)) bus ();
  icache_tag_array #(.WAYS(4), .SETS(128), .TAG_W(18)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  typedef struct {
    logic        do_wr;
    logic [6:0]  wi;
    logic [1:0]  ww;
    logic [17:0] wt;
    logic [6:0]  li;
    logic [17:0] lt;
    logic        eh;
    logic [1:0]  ew;
    logic [3:0]  ev;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.busy) busy_cnt++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && bus.busy; i++) step();
    chk("busy_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic do_write(input logic [6:0] idx, input logic [1:0] way, input logic [17:0] tag);
    bus.wr_en = 1'b1; bus.wr_index = idx; bus.wr_way = way; bus.wr_tag = tag;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [6:0] idx, input logic [17:0] tag);
    bus.lk_en = 1'b1; bus.lk_index = idx; bus.lk_tag = tag;
    step();
    bus.lk_en = 1'b0;
    step();
  endtask

  task automatic chk_rsp(input string name, input logic eh, input logic [1:0] ew, input logic [3:0] ev);
    chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({name, "_hit"}, 64'(bus.hit), 64'(eh));
    chk({name, "_hit_way"}, 64'(bus.hit_way), 64'(ew));
    chk({name, "_valid_out"}, 64'(bus.valid_out), 64'(ev));
`ifndef ICACHE_TAG_PARITY_EN
    chk({name, "_parity_err"}, 64'(bus.parity_err), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lk_en = 0; bus.lk_index = '0; bus.lk_tag = '0;
    bus.wr_en = 0; bus.wr_index = '0; bus.wr_way = '0; bus.wr_tag = '0;
    bus.inv_all = 0;

    vecs[0] = '{1'b1, 7'd5,   2'd2, 18'h2A5A5, 7'd5,   18'h2A5A5, 1'b1, 2'd2, 4'b0100};
    vecs[1] = '{1'b0, 7'd0,   2'd0, 18'h0,     7'd5,   18'h00001, 1'b0, 2'd0, 4'b0100};
    vecs[2] = '{1'b1, 7'd5,   2'd0, 18'h3FFFF, 7'd5,   18'h3FFFF, 1'b1, 2'd0, 4'b0101};
    vecs[3] = '{1'b1, 7'd5,   2'd0, 18'h2A5A5, 7'd5,   18'h2A5A5, 1'b1, 2'd0, 4'b0101};
    vecs[4] = '{1'b0, 7'd0,   2'd0, 18'h0,     7'd5,   18'h3FFFF, 1'b0, 2'd0, 4'b0101};
    vecs[5] = '{1'b1, 7'd6,   2'd3, 18'h2A5A5, 7'd6,   18'h2A5A5, 1'b1, 2'd3, 4'b1000};
    vecs[6] = '{1'b0, 7'd0,   2'd0, 18'h0,     7'd4,   18'h2A5A5, 1'b0, 2'd0, 4'b0000};
    vecs[7] = '{1'b1, 7'd127, 2'd1, 18'h00ABC, 7'd127, 18'h00ABC, 1'b1, 2'd1, 4'b0010};
    vecs[8] = '{1'b0, 7'd0,   2'd0, 18'h0,     7'd0,   18'h00ABC, 1'b0, 2'd0, 4'b0000};

    // Reset and initial sweep
    busy_cnt = 0;
    step();
    chk("rst_busy", 64'(bus.busy), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_hit", 64'(bus.hit), 64'd0);
    chk("rst_hit_way", 64'(bus.hit_way), 64'd0);
    chk("rst_tags_out", 64'(|bus.tags_out), 64'd0);
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_parity_err", 64'(bus.parity_err), 64'd0);
    rst = 1'b0;
    wait_idle();
    chk("rst_busy_cycles", 64'(busy_cnt), 64'd128);

    for (int s = 0; s < 128; s++) begin
      do_lookup(7'(s), 18'h0);
      chk("post_rst_hit", 64'(bus.hit), 64'd0);
      chk("post_rst_valid", 64'(bus.valid_out), 64'd0);
    end

    // Table-driven write/lookup vectors
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].wi, vecs[i].ww, vecs[i].wt);
      step();
      do_lookup(vecs[i].li, vecs[i].lt);
      chk_rsp($sformatf("vec%0d", i), vecs[i].eh, vecs[i].ew, vecs[i].ev);
      if (vecs[i].eh)
        chk($sformatf("vec%0d_tags", i), 64'(bus.tags_out[vecs[i].ew*18 +: 18]), 64'(vecs[i].lt));
    end

    // Forwarding: write on the same edge as the lookup
    bus.lk_en = 1; bus.lk_index = 7'd9; bus.lk_tag = 18'h01234;
    bus.wr_en = 1; bus.wr_index = 7'd9; bus.wr_way = 2'd3; bus.wr_tag = 18'h01234;
    step();
    bus.lk_en = 0; bus.wr_en = 0;
    step();
    chk_rsp("fwd_n", 1'b1, 2'd3, 4'b1000);
    chk("fwd_n_tags", 64'(bus.tags_out[54 +: 18]), 64'h01234);

    // Forwarding: write one edge after the lookup
    bus.lk_en = 1; bus.lk_index = 7'd10; bus.lk_tag = 18'h01234;
    step();
    bus.lk_en = 0;
    bus.wr_en = 1; bus.wr_index = 7'd10; bus.wr_way = 2'd3; bus.wr_tag = 18'h01234;
    step();
    bus.wr_en = 0;
    chk_rsp("fwd_n1", 1'b1, 2'd3, 4'b1000);

    // Back-to-back lookups
    do_write(7'd1, 2'd0, 18'h00111);
    do_write(7'd2, 2'd1, 18'h00222);
    do_write(7'd3, 2'd3, 18'h00333);
    bus.lk_en = 1; bus.lk_index = 7'd1; bus.lk_tag = 18'h00111;
    step();
    bus.lk_index = 7'd2; bus.lk_tag = 18'h00222;
    step();
    chk_rsp("b2b_1", 1'b1, 2'd0, 4'b0001);
    bus.lk_index = 7'd3; bus.lk_tag = 18'h00333;
    step();
    chk_rsp("b2b_2", 1'b1, 2'd1, 4'b0010);
    bus.lk_en = 0;
    step();
    chk_rsp("b2b_3", 1'b1, 2'd3, 4'b1000);
    step();
    chk("b2b_idle_rsp", 64'(bus.rsp_valid), 64'd0);

    // Invalidate sweep with a lookup in flight, plus dropped write and busy lookup
    for (int w = 0; w < 4; w++) do_write(7'd0, 2'(w), 18'(16 + w));
    do_lookup(7'd0, 18'h00012);
    chk_rsp("inv_pre", 1'b1, 2'd2, 4'b1111);
    bus.lk_en = 1; bus.lk_index = 7'd0; bus.lk_tag = 18'h00013;
    step();
    bus.lk_en = 0; bus.inv_all = 1;
    busy_cnt = 0;
    step();
    chk_rsp("inv_inflight", 1'b1, 2'd3, 4'b1111);
    chk("inv_busy", 64'(bus.busy), 64'd1);
    bus.wr_en = 1; bus.wr_index = 7'd0; bus.wr_way = 2'd0; bus.wr_tag = 18'h00055;
    bus.lk_en = 1; bus.lk_index = 7'd0; bus.lk_tag = 18'h00055;
    step();
    bus.wr_en = 0; bus.lk_en = 0; bus.inv_all = 0;
    step();
    chk_rsp("inv_busy_lk", 1'b0, 2'd0, 4'b0000);
    wait_idle();
    chk("inv_busy_cycles", 64'(busy_cnt), 64'd128);
    do_lookup(7'd0, 18'h00055);
    chk_rsp("inv_dropped_wr", 1'b0, 2'd0, 4'b0000);
    do_lookup(7'd0, 18'h00010);
    chk_rsp("inv_after", 1'b0, 2'd0, 4'b0000);

`ifdef ICACHE_TAG_PARITY_EN
    do_write(7'd7, 2'd1, 18'h12345);
    step();
    dut.tag_ram[7][1][0] = ~dut.tag_ram[7][1][0];
    do_lookup(7'd7, 18'h12345);
    chk("par_hit", 64'(bus.hit), 64'd0);
    chk("par_err", 64'(bus.parity_err), 64'd1);
    step();
    chk("par_err_pulse", 64'(bus.parity_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
